mc_alu: RTL
===========

// Module: mc_alu
// PURPOSE
//  Parametrised multi-cycle ALU for the IBMinator datapath; successor to the single-cycle ALU.
//  Single-cycle logic/shift/add ops plus iterative signed/unsigned MULT/DIV with 2*WIDTH result (hi/lo).
//  Valid/ready handshake lets the pipeline stall on long ops; sits in EX between decode and cache/WB.
// PARAMETERS
//  WIDTH      32  operand/result width (power of 2, >=8)
//  SHW        $clog2(WIDTH)  shift-amount width (derived, not overridable)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_b      in   1       reset: synchronous, active-high
//  in_valid   in   1       operation request
//  in_ready   out  1       1 = can accept request this cycle
//  op         in   6       alu_op_e (mc_alu_pkg)
//  a          in   WIDTH   operand 1 (rs)
//  b          in   WIDTH   operand 2 (rt / extended immediate)
//  shamt      in   SHW     immediate shift amount
//  out_valid  out  1       1-cycle pulse: result fields valid
//  result     out  WIDTH   primary result (LO for MULT/DIV = product low / quotient)
//  result_hi  out  WIDTH   MULT: product high; DIV: remainder; else 0
//  cond       out  1       branch-condition true (BEQ/BNE/BLEZ/BGTZ/BGEZ); else 0
//  ovf        out  1       signed overflow on ADD/SUB; else 0
//  div0       out  1       DIV/DIVU with b==0
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, result=result_hi=0, cond=ovf=div0=0, FSM->IDLE.
//  Reset mid-MUL/DIV aborts op; no out_valid for it.
//  Accept = in_valid & in_ready. in_ready = (state==IDLE). in_valid while busy ignored.
//  FSM: IDLE -(accept, short op)-> IDLE, registered result, out_valid next cycle (latency 1).
//       IDLE -(accept, MULT/MULTU)-> MUL; IDLE -(accept, DIV/DIVU)-> DIV.
//       MUL/DIV: WIDTH iterations, one bit per cycle, counter WIDTH-1..0; at 0 -> FIN.
//       FIN: sign fix-up, register outputs, out_valid=1 -> IDLE. Latency MUL/DIV = WIDTH+2.
//  Back-to-back short ops: accept every cycle, out_valid every cycle.
//  Outputs hold last values when out_valid=0; only sample on out_valid.
//  Short ops (1 cycle): ADD/SUB signed with ovf; ADDU/SUBU no ovf; AND/OR/XOR/NOR full WIDTH;
//   SLT signed, SLTU unsigned -> 0/1; SLL/SRL/SRA by shamt; SLLV/SRLV/SRAV by a[SHW-1:0];
//   LUI: {b[WIDTH/2-1:0], WIDTH/2 zeros}.
//  Branch ops: result=0; BEQ a==b; BNE a!=b; BLEZ $signed(a)<=0; BGTZ >0; BGEZ >=0.
//  MULT/DIV signed: operate on magnitudes, negate product if signs differ; quotient sign = a^b,
//   remainder sign = sign of a (truncating division). Unsigned variants skip fix-up.
//  DIV by zero: no iteration hazard; quotient=all ones, remainder=a, div0=1, same latency.
//  Most-negative / -1 (signed DIV): quotient=most-negative, remainder=0, no trap.
//  Unknown op: accepted, single-cycle, result=result_hi=0, flags 0.
//  No latches: all combinational paths fully assigned; every flop reset.
// STRUCTURE
//  mc_alu_pkg: alu_op_e (6-bit codes, MIPS funct values for R-type; 0x38.. for branch/LUI),
//   state_e {IDLE,MUL,DIV,FIN}, is_long_op() function.
//  Sub-module mc_alu_iter: shared shift-add / restoring-subtract datapath (acc, mq, count);
//   top holds FSM, short-op logic, sign fix-up, output regs.
// TESTING (WIDTH=32)
//  ADD 0x7FFFFFFF+1 -> result 0x80000000, ovf=1, out_valid one cycle after accept; ADDU same, ovf=0.
//  SRA 0x80000000 shamt 4 -> 0xF8000000; SRLV a=36 b=0x100 -> 0x10 (uses a[4:0]=4).
//  MULT -3*7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB at accept+34; in_ready=0 during, in_valid ignored.
//  DIV -7/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF hi=7 div0=1.
//  BGEZ a=0 -> cond=1; BLEZ a=0x80000000 -> cond=1; BNE a=b=5 -> cond=0.
//  rst_b high at iteration 10 of DIV -> next cycle in_ready=1, outputs 0, no out_valid.

Source files
------------

// File: rtl/mc_alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding, FSM states and op classifiers.
package mc_alu_pkg;

    // R-type codes follow MIPS funct values; branch/LUI codes start at 0x38.
    typedef enum logic [5:0] {
        OP_SLL   = 6'h00, OP_SRL   = 6'h02, OP_SRA   = 6'h03,
        OP_SLLV  = 6'h04, OP_SRLV  = 6'h06, OP_SRAV  = 6'h07,
        OP_MULT  = 6'h18, OP_MULTU = 6'h19, OP_DIV   = 6'h1A, OP_DIVU = 6'h1B,
        OP_ADD   = 6'h20, OP_ADDU  = 6'h21, OP_SUB   = 6'h22, OP_SUBU = 6'h23,
        OP_AND   = 6'h24, OP_OR    = 6'h25, OP_XOR   = 6'h26, OP_NOR  = 6'h27,
        OP_SLT   = 6'h2A, OP_SLTU  = 6'h2B,
        OP_BEQ   = 6'h38, OP_BNE   = 6'h39, OP_BLEZ  = 6'h3A, OP_BGTZ = 6'h3B,
        OP_BGEZ  = 6'h3C, OP_LUI   = 6'h3D
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_e;

    // Ops that go through the iterative datapath.
    function automatic logic is_long_op(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [5:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_long(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mc_alu_if.sv
// Request/response bundle between the EX stage controller (master) and the ALU (slave).
interface mc_alu_if #(parameter int WIDTH = 32);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [5:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             cond;
    logic             ovf;
    logic             div0;

    modport master (output in_valid, op, a, b, shamt,
                    input  in_ready, out_valid, result, result_hi, cond, ovf, div0);
    modport slave  (input  in_valid, op, a, b, shamt,
                    output in_ready, out_valid, result, result_hi, cond, ovf, div0);
endinterface

// File: rtl/mc_alu_iter.sv
// Shared one-bit-per-cycle datapath: shift-add multiply and restoring divide on magnitudes.
// Multiply: {acc,mq} ends as the 2*WIDTH product. Divide: mq ends as quotient, acc as remainder.
module mc_alu_iter #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mq_o,
    output logic             done_o
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, opb_q, opb_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;

    assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_q, mq_q[WIDTH-1]};
    // A divisor of zero never borrows, so the quotient fills with ones and acc collects the dividend.
    assign div_trial = div_shift - {1'b0, opb_q};

    // Next-state for one iteration step or a fresh operand load.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        acc_d = acc_q;
        mq_d  = mq_q;
        opb_d = opb_q;
        cnt_d = cnt_q;
        if (load_i) begin
            acc_d = '0;
            mq_d  = opa_i;
            opb_d = opb_i;
            cnt_d = SHW'(WIDTH - 1);
        end else if (step_i) begin
            cnt_d = cnt_q - 1'b1;
            if (is_div_i) begin
                if (!div_trial[WIDTH]) begin
                    acc_d = div_trial[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = mul_sum[WIDTH:1];
                mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst_b) begin
            acc_q <= '0;
            mq_q  <= '0;
            opb_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            mq_q  <= mq_d;
            opb_q <= opb_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o  = acc_q;
    assign mq_o   = mq_q;
    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/shift/add/branch ops, iterative MULT/DIV with hi/lo result.
module mc_alu
    import mc_alu_pkg::*;
#(parameter int WIDTH = 32) (
    input  logic     clk,
    input  logic     rst_b,
    mc_alu_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic               accept, long_op, div_op, op_signed;
    logic               iter_load, iter_step, iter_done;
    logic [WIDTH-1:0]   a_mag, b_mag, acc, mq, a_q;
    logic               neg_lo_q, neg_hi_q, is_div_q, div0_p_q;
    logic [WIDTH-1:0]   sum, diff;
    logic [SHW-1:0]     vamt;
    logic [WIDTH-1:0]   short_res, fin_lo, fin_hi;
    logic               short_cond, short_ovf;
    logic [2*WIDTH-1:0] prod;
    logic               out_valid_q, cond_q, ovf_q, div0_q;
    logic [WIDTH-1:0]   result_q, result_hi_q;

    assign bus.in_ready = (state_q == IDLE);
    assign accept       = bus.in_valid && (state_q == IDLE);
    assign long_op      = is_long_op(bus.op);
    assign div_op       = is_div_op(bus.op);
    assign op_signed    = is_signed_long(bus.op);
    assign a_mag        = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag        = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    mc_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_b    (rst_b),
        .load_i   (iter_load),
        .step_i   (iter_step),
        .is_div_i (state_q == DIV),
        .opa_i    (a_mag),
        .opb_i    (b_mag),
        .acc_o    (acc),
        .mq_o     (mq),
        .done_o   (iter_done)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst_b) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state and iteration controls.
    always_comb begin
        state_d   = state_q;
        iter_load = 1'b0;
        iter_step = 1'b0;
        case (state_q)
            IDLE: if (accept && long_op) begin
                iter_load = 1'b1;
                state_d   = div_op ? DIV : MUL;
            end
            MUL, DIV: begin
                iter_step = 1'b1;
                if (iter_done) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;
    assign vamt = bus.a[SHW-1:0];

    // Single-cycle ops; unknown codes fall through to all-zero.
    always_comb begin
        short_res  = '0;
        short_cond = 1'b0;
        short_ovf  = 1'b0;
        case (bus.op)
            OP_ADD:  begin
                short_res = sum;
                short_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB:  begin
                short_res = diff;
                short_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_ADDU: short_res = sum;
            OP_SUBU: short_res = diff;
            OP_AND:  short_res = bus.a & bus.b;
            OP_OR:   short_res = bus.a | bus.b;
            OP_XOR:  short_res = bus.a ^ bus.b;
            OP_NOR:  short_res = ~(bus.a | bus.b);
            OP_SLT:  short_res = WIDTH'($signed(bus.a) < $signed(bus.b));
            OP_SLTU: short_res = WIDTH'(bus.a < bus.b);
            OP_SLL:  short_res = bus.b << bus.shamt;
            OP_SRL:  short_res = bus.b >> bus.shamt;
            OP_SRA:  short_res = $signed(bus.b) >>> bus.shamt;
            OP_SLLV: short_res = bus.b << vamt;
            OP_SRLV: short_res = bus.b >> vamt;
            OP_SRAV: short_res = $signed(bus.b) >>> vamt;
            OP_LUI:  short_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_BEQ:  short_cond = (bus.a == bus.b);
            OP_BNE:  short_cond = (bus.a != bus.b);
            OP_BLEZ: short_cond = bus.a[WIDTH-1] || (bus.a == '0);
            OP_BGTZ: short_cond = !bus.a[WIDTH-1] && (bus.a != '0);
            OP_BGEZ: short_cond = !bus.a[WIDTH-1];
            default: ;
        endcase
    end

    // Sign fix-up of the iterative result; divide-by-zero bypasses it.
    always_comb begin
        prod   = {acc, mq};
        fin_lo = '0;
        fin_hi = '0;
        if (is_div_q) begin
            if (div0_p_q) begin
                fin_lo = '1;
                fin_hi = a_q;
            end else begin
                fin_lo = neg_lo_q ? -mq  : mq;
                fin_hi = neg_hi_q ? -acc : acc;
            end
        end else begin
            if (neg_lo_q) prod = -prod;
            fin_lo = prod[WIDTH-1:0];
            fin_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    // Long-op context captured at accept, plus registered outputs.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            is_div_q    <= 1'b0;
            div0_p_q    <= 1'b0;
            a_q         <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            cond_q      <= 1'b0;
            ovf_q       <= 1'b0;
            div0_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept && long_op) begin
                neg_lo_q <= op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_hi_q <= op_signed && div_op && bus.a[WIDTH-1];
                is_div_q <= div_op;
                div0_p_q <= div_op && (bus.b == '0);
                a_q      <= bus.a;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                result_q    <= short_res;
                result_hi_q <= '0;
                cond_q      <= short_cond;
                ovf_q       <= short_ovf;
                div0_q      <= 1'b0;
            end else if (state_q == FIN) begin
                out_valid_q <= 1'b1;
                result_q    <= fin_lo;
                result_hi_q <= fin_hi;
                cond_q      <= 1'b0;
                ovf_q       <= 1'b0;
                div0_q      <= div0_p_q;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.cond      = cond_q;
    assign bus.ovf       = ovf_q;
    assign bus.div0      = div0_q;
endmodule
